regfile_sb: RTL and testbench

- Parametrised register file for the pipelined Y86-64 core, generalised from the fixed 15x64 file.
- Two combinational read ports (decode srcA/srcB) with write-through bypass from two writeback ports (E and M).
- Per-register pending-write scoreboard: counts in-flight writes, flags decode hazards, and reports over/underflow.
- Registered debug read port replaces the 15 flat reg_memN outputs.

---
 rtl/regfile_sb.sv | 173 +++++++++++++++++
 tb/tb_regfile_sb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Y86-64 register file, two bypassed read ports, pending-write
//            scoreboard with hazard flags, registered debug read port.
// Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W      = 64,
    parameter int NREGS       = 15,
    parameter int ID_W        = 4,
    parameter int RNONE       = 15,
    parameter int PEND_W      = 2,
    parameter int RESET_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   rd_srcA,
    input  logic [ID_W-1:0]   rd_srcB,
    output logic [DATA_W-1:0] rd_valA,
    output logic [DATA_W-1:0] rd_valB,
    output logic              hz_A,
    output logic              hz_B,
    input  logic              wb_valid,
    input  logic [ID_W-1:0]   wb_dstE,
    input  logic [DATA_W-1:0] wb_valE,
    input  logic [ID_W-1:0]   wb_dstM,
    input  logic [DATA_W-1:0] wb_valM,
    input  logic              iss_valid,
    input  logic [ID_W-1:0]   iss_dstE,
    input  logic [ID_W-1:0]   iss_dstM,
    input  logic [ID_W-1:0]   dbg_sel,
    output logic [DATA_W-1:0] dbg_val,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int             CW       = PEND_W + 2;
    localparam logic [CW-1:0]  PEND_MAX = CW'((1 << PEND_W) - 1);

    function automatic logic id_ok(input logic [ID_W-1:0] id);
        return (int'(id) != RNONE) && (int'(id) < NREGS);
    endfunction

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  hz_vec;
    logic [NREGS-1:0]  ovf_hit;
    logic [NREGS-1:0]  unf_hit;

    logic wb_e_ok, wb_m_ok, iss_e_ok, iss_m_ok;

    always_comb begin
        wb_e_ok  = wb_valid  && id_ok(wb_dstE);
        wb_m_ok  = wb_valid  && id_ok(wb_dstM);
        iss_e_ok = iss_valid && id_ok(iss_dstE);
        iss_m_ok = iss_valid && id_ok(iss_dstM);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [ID_W-1:0] RID = ID_W'(gi);

            logic [DATA_W-1:0] val_q;
            logic [PEND_W-1:0] pend_q;
            logic [PEND_W-1:0] pend_nxt;
            logic [1:0]        inc;
            logic [1:0]        dec;
            logic [CW-1:0]     sum_up;
            logic [CW-1:0]     diff;
            logic              ovf;
            logic              unf;

            // Counter arithmetic is done two bits wider so both saturation
            // directions are detectable before clamping.
            always_comb begin
                inc      = {1'b0, iss_e_ok && (iss_dstE == RID)}
                         + {1'b0, iss_m_ok && (iss_dstM == RID)};
                dec      = {1'b0, wb_e_ok && (wb_dstE == RID)}
                         + {1'b0, wb_m_ok && (wb_dstM == RID)};
                sum_up   = {2'b00, pend_q} + CW'(inc);
                diff     = sum_up - CW'(dec);
                ovf      = 1'b0;
                unf      = 1'b0;
                pend_nxt = pend_q;
                if (sum_up < CW'(dec)) begin
                    unf      = 1'b1;
                    pend_nxt = '0;
                end else if (diff > PEND_MAX) begin
                    ovf      = 1'b1;
                    pend_nxt = PEND_MAX[PEND_W-1:0];
                end else begin
                    pend_nxt = diff[PEND_W-1:0];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_q <= '0;
                    val_q  <= (RESET_INDEX != 0) ? DATA_W'(gi) : '0;
                end else begin
                    pend_q <= pend_nxt;
                    if (wb_m_ok && (wb_dstM == RID)) begin
                        val_q <= wb_valM;
                    end else if (wb_e_ok && (wb_dstE == RID)) begin
                        val_q <= wb_valE;
                    end
                end
            end

            // Hazard ignores same-cycle issue; a retiring write clears it now.
            assign hz_vec[gi]  = ({2'b00, pend_q} > CW'(dec));
            assign ovf_hit[gi] = ovf;
            assign unf_hit[gi] = unf;
            assign regs[gi]    = val_q;
        end
    endgenerate

    logic [DATA_W-1:0] stored_a, stored_b, stored_dbg;
    logic              pend_a, pend_b;

    always_comb begin
        stored_a   = '0;
        stored_b   = '0;
        stored_dbg = '0;
        pend_a     = 1'b0;
        pend_b     = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_srcA == ID_W'(i)) begin
                stored_a = regs[i];
                pend_a   = hz_vec[i];
            end
            if (rd_srcB == ID_W'(i)) begin
                stored_b = regs[i];
                pend_b   = hz_vec[i];
            end
            if (dbg_sel == ID_W'(i)) begin
                stored_dbg = regs[i];
            end
        end
    end

    always_comb begin
        rd_valA = '0;
        if (id_ok(rd_srcA)) begin
            if (wb_m_ok && (wb_dstM == rd_srcA))      rd_valA = wb_valM;
            else if (wb_e_ok && (wb_dstE == rd_srcA)) rd_valA = wb_valE;
            else                                      rd_valA = stored_a;
        end
        rd_valB = '0;
        if (id_ok(rd_srcB)) begin
            if (wb_m_ok && (wb_dstM == rd_srcB))      rd_valB = wb_valM;
            else if (wb_e_ok && (wb_dstE == rd_srcB)) rd_valB = wb_valE;
            else                                      rd_valB = stored_b;
        end
        hz_A = id_ok(rd_srcA) && pend_a;
        hz_B = id_ok(rd_srcB) && pend_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_val <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            dbg_val <= id_ok(dbg_sel) ? stored_dbg : '0;
            err_ovf <= err_ovf | (|ovf_hit);
            err_unf <= err_unf | (|unf_hit);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed and randomized checks of regfile_sb against a
//            behavioural model (integer arrays, plain arithmetic).
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

    localparam int NR   = 15;
    localparam int NONE = 15;
    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rd_srcA, rd_srcB, wb_dstE, wb_dstM, iss_dstE, iss_dstM, dbg_sel;
    logic [63:0] rd_valA, rd_valB, wb_valE, wb_valM, dbg_val;
    logic        hz_A, hz_B, wb_valid, iss_valid, err_ovf, err_unf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [63:0] m_regs [NR];
    int          m_pend [NR];
    logic [63:0] m_dbg;
    logic        m_ovf, m_unf;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .rd_srcA(rd_srcA), .rd_srcB(rd_srcB),
        .rd_valA(rd_valA), .rd_valB(rd_valB),
        .hz_A(hz_A), .hz_B(hz_B),
        .wb_valid(wb_valid), .wb_dstE(wb_dstE), .wb_valE(wb_valE),
        .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .iss_valid(iss_valid), .iss_dstE(iss_dstE), .iss_dstM(iss_dstM),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    function automatic bit vid(input int id);
        return (id != NONE) && (id < NR);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 64'(i);
            m_pend[i] = 0;
        end
        m_dbg = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic int dec_of(input int r);
        return wb_valid ? ((int'(wb_dstE) == r) + (int'(wb_dstM) == r)) : 0;
    endfunction

    function automatic logic [63:0] exp_read(input int src);
        if (!vid(src))                            return '0;
        if (wb_valid && int'(wb_dstM) == src)     return wb_valM;
        if (wb_valid && int'(wb_dstE) == src)     return wb_valE;
        return m_regs[src];
    endfunction

    function automatic logic exp_hz(input int src);
        if (!vid(src)) return 1'b0;
        return (m_pend[src] - dec_of(src)) > 0;
    endfunction

    // Applies one rising edge's worth of architectural effect to the model.
    task automatic model_edge();
        int inc, dec, n;
        m_dbg = vid(int'(dbg_sel)) ? m_regs[dbg_sel] : 64'h0;
        for (int r = 0; r < NR; r++) begin
            inc = iss_valid ? ((int'(iss_dstE) == r) + (int'(iss_dstM) == r)) : 0;
            dec = dec_of(r);
            n   = m_pend[r] + inc - dec;
            if (n < 0) begin
                n = 0;
                m_unf = 1'b1;
            end else if (n > PMAX) begin
                n = PMAX;
                m_ovf = 1'b1;
            end
            m_pend[r] = n;
        end
        if (wb_valid) begin
            if (vid(int'(wb_dstE))) m_regs[wb_dstE] = wb_valE;
            if (vid(int'(wb_dstM))) m_regs[wb_dstM] = wb_valM;
        end
    endtask

    task automatic check_all();
        chk("rd_valA", rd_valA, exp_read(int'(rd_srcA)));
        chk("rd_valB", rd_valB, exp_read(int'(rd_srcB)));
        chk("hz_A", 64'(hz_A), 64'(exp_hz(int'(rd_srcA))));
        chk("hz_B", 64'(hz_B), 64'(exp_hz(int'(rd_srcB))));
        chk("dbg_val", dbg_val, m_dbg);
        chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
        chk("err_unf", 64'(err_unf), 64'(m_unf));
    endtask

    // Inputs are set just after a falling edge; this checks, clocks, and
    // returns at the next falling edge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_valid = 0; iss_valid = 0;
        wb_dstE = 4'hF; wb_dstM = 4'hF; wb_valE = '0; wb_valM = '0;
        iss_dstE = 4'hF; iss_dstM = 4'hF;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [3:0] rid();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_n = 0; rd_srcA = 0; rd_srcB = 0; dbg_sel = 0;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset values and debug latency
        rd_srcA = 3; rd_srcB = 15; dbg_sel = 14;
        #1;
        chk("rst_valA", rd_valA, 64'd3);
        chk("rst_valB", rd_valB, 64'd0);
        chk("rst_hz", 64'({hz_A, hz_B}), 64'd0);
        chk("rst_dbg", dbg_val, 64'd0);
        step();
        chk("dbg14", dbg_val, 64'd14);

        // Bypass then storage
        wb_valid = 1; wb_dstE = 2; wb_valE = 64'hAA; rd_srcA = 2;
        #1 chk("bypassE", rd_valA, 64'hAA);
        step();
        idle();
        #1 chk("storedE", rd_valA, 64'hAA);
        step();

        // E/M collision: M wins
        wb_valid = 1; wb_dstE = 4; wb_dstM = 4; wb_valE = 64'h100; wb_valM = 64'h200;
        rd_srcA = 4;
        #1 chk("collide_byp", rd_valA, 64'h200);
        step();
        idle();
        #1 chk("collide_reg", rd_valA, 64'h200);
        step();

        // Scoreboard on r5
        do_reset();
        iss_valid = 1; iss_dstE = 5;
        step();
        step();
        idle(); rd_srcA = 5;
        #1 chk("sb_pend2", 64'(hz_A), 64'd1);
        wb_valid = 1; wb_dstE = 5; wb_valE = 64'h51;
        #1 chk("sb_wb1", 64'(hz_A), 64'd1);
        step();
        wb_valid = 1; wb_dstE = 5; wb_valE = 64'h55;
        #1 chk("sb_wb2_hz", 64'(hz_A), 64'd0);
        chk("sb_wb2_val", rd_valA, 64'h55);
        step();
        idle();

        // Overflow on r6
        iss_valid = 1; iss_dstE = 6; iss_dstM = 6;
        step();
        step();
        idle(); rd_srcA = 6;
        #1 chk("ovf_set", 64'(err_ovf), 64'd1);
        chk("ovf_hz", 64'(hz_A), 64'd1);
        step();
        chk("ovf_sticky", 64'(err_ovf), 64'd1);

        // Underflow, then asynchronous reset in mid-cycle
        do_reset();
        wb_valid = 1; wb_dstE = 7; wb_valE = 64'h77;
        step();
        idle(); rd_srcA = 7; rd_srcB = 6;
        #1 chk("unf_set", 64'(err_unf), 64'd1);
        chk("unf_val", rd_valA, 64'h77);
        #1 rst_n = 0;
        model_reset();
        #1 chk("arst_unf", 64'(err_unf), 64'd0);
        chk("arst_r7", rd_valA, 64'd7);
        chk("arst_hz", 64'({hz_A, hz_B}), 64'd0);
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the model
        for (int round = 0; round < 6; round++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                rd_srcA   = rid();
                rd_srcB   = rid();
                dbg_sel   = 4'($urandom_range(0, 15));
                iss_valid = 1'($urandom_range(0, 1));
                iss_dstE  = rid();
                iss_dstM  = rid();
                wb_valid  = 1'($urandom_range(0, 1));
                wb_dstE   = rid();
                wb_dstM   = rid();
                wb_valE   = {$urandom, $urandom};
                wb_valM   = {$urandom, $urandom};
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
